// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access sequencer: access-size codes and FSM states.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/mem_lane_merge.sv
// Little-endian lane logic: extracts/extends load data and merges store data into a memory word.
module mem_lane_merge
  import mem_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        signed_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    load_o   = '0;
    store_o  = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        store_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o = {{16{signed_i & half_sel[15]}}, half_sel};
        store_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      SZ_WORD: begin
        load_o  = rdata_i;
        store_o = wdata_i;
      end
      default: begin
        load_o  = '0;
        store_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_seq.sv
// CPU load/store sequencer with read-modify-write for sub-word stores.
// Define MEM_ACCESS_ALIGN_CHECK_EN to fault misaligned halves/words instead of aligning them down.
module mem_access_seq
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        write_q, write_d;
  logic        fault_q, fault_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        req_fault;
  logic [31:0] load_data, store_word;

  always_comb begin
    req_fault = (req_size == SZ_RSVD);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if ((req_size == SZ_HALF) && req_addr[0])
      req_fault = 1'b1;
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
      req_fault = 1'b1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          size_d   = req_size;
          signed_d = req_signed;
          write_d  = req_write;
          fault_d  = req_fault;
          cnt_d    = 2'(MEM_LAT - 1);
          if (req_fault)
            state_d = ST_RESP;
          else if (req_write && (req_size == SZ_WORD))
            state_d = ST_WRITE;
          else
            state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // Sub-word stores fall through to WRITE once the old word has arrived.
        if (cnt_q == 2'd0)
          state_d = write_q ? ST_WRITE : ST_RESP;
        else
          cnt_d = cnt_q - 2'd1;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      write_q  <= write_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  mem_lane_merge u_lane (
    .size_i   (size_q),
    .addr_lo_i(addr_q[1:0]),
    .signed_i (signed_q),
    .rdata_i  (mem_rdata),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .store_o  (store_word)
  );

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_fault = resp_valid & fault_q;
    resp_rdata = (resp_valid && !write_q && !fault_q) ? load_data : '0;
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_wr     = (state_q == ST_WRITE);
    mem_wdata  = mem_wr ? store_word : '0;
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Randomized and directed checks of mem_access_seq against an arithmetic reference model.
module tb_mem_access_seq;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr;

  int unsigned n_checks = 0;
  int unsigned n_err = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] apipe   [0:LAT-1];

  mem_access_seq #(.MEM_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: data for an address appears LAT cycles after the address is presented.
  assign mem_rdata = mem[apipe[LAT-1][9:2]];

  always @(posedge clk) begin
    apipe[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_fault(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`else
    return (sz == 2'd3) || (a === 32'hx);
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input logic [31:0] a);
    logic [31:0] v;
    int unsigned sh;
    v = 32'h0;
    if (sz == 2'd0) begin
      sh = 8 * a[1:0];
      v = (w >> sh) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      sh = 16 * a[1];
      v = (w >> sh) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end else if (sz == 2'd2) begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    int unsigned sh;
    if (sz == 2'd0) begin
      sh = 8 * a[1:0];
      mask = 32'hFF << sh;
    end else if (sz == 2'd1) begin
      sh = 16 * a[1];
      mask = 32'hFFFF << sh;
    end else begin
      sh = 0;
      mask = 32'hFFFFFFFF;
    end
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
    ref_mem[a[9:2]] = w;
  endtask

  task automatic wait_ready();
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("ready_before_req", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd_o);
    int cyc, nwr, exp_lat;
    logic [31:0] wa, wdat, al, old_w, exp_rd;
    logic addr_ok, flt;
    wait_ready();
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    al     = {a[31:2], 2'b00};
    flt    = model_fault(sz, a);
    old_w  = ref_mem[a[9:2]];
    exp_rd = (flt || wr) ? 32'h0 : model_load(old_w, sz, sg, a);
    if (flt) exp_lat = 1;
    else if (wr && sz == 2'd2) exp_lat = 2;
    else if (wr) exp_lat = LAT + 2;
    else exp_lat = LAT + 1;
    cyc = 0; nwr = 0; addr_ok = 1'b1; wa = '0; wdat = '0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_addr !== al) addr_ok = 1'b0;
      if (mem_wr) begin
        nwr++;
        wa = mem_addr;
        wdat = mem_wdata;
      end
    end while (!resp_valid && cyc < 20);
    rd_o = resp_rdata;
    check_eq("resp_latency", cyc, exp_lat);
    check_eq("resp_fault", {31'd0, resp_fault}, {31'd0, flt});
    check_eq("resp_rdata", resp_rdata, exp_rd);
    check_eq("mem_addr_hold", {31'd0, addr_ok}, 32'd1);
    check_eq("mem_wr_count", nwr, (wr && !flt) ? 1 : 0);
    if (wr && !flt) begin
      check_eq("mem_wr_addr", wa, al);
      check_eq("mem_wdata", wdat, model_store(old_w, sz, a, wd));
      ref_mem[a[9:2]] = model_store(old_w, sz, a, wd);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int n_acc, n_resp, acc0, acc1;
    logic bad;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < LAT; i++) apipe[i] = '0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = '0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    #1;
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_outputs", {29'd0, resp_valid, resp_fault, mem_wr}, 32'd0);
    check_eq("rst_data", resp_rdata | mem_addr | mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    set_word(32'h100, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd);
    check_eq("ld_word_literal", rd, 32'hDEADBEEF);

    set_word(32'h100, 32'h80FF0011);
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, rd);
    check_eq("ld_sbyte_literal", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, rd);
    check_eq("ld_ubyte_literal", rd, 32'h00000080);

    set_word(32'h200, 32'h11223344);
    do_req(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, rd);
    check_eq("st_half_literal", mem[32'h200 >> 2], 32'hABCD3344);

    set_word(32'h100, 32'h13579BDF);
    do_req(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, rd);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    check_eq("misaligned_word_literal", rd, 32'h0);
`else
    check_eq("misaligned_word_literal", rd, 32'h13579BDF);
`endif
    do_req(1'b1, 2'd3, 1'b0, 32'h204, 32'h55AA55AA, rd);

    // Reset in the second RD_WAIT cycle of a byte store.
    wait_ready();
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h305; req_wdata = 32'h000000EE;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("midrst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("midrst_outputs", {29'd0, resp_valid, resp_fault, mem_wr}, 32'd0);
    check_eq("midrst_data", resp_rdata | mem_addr | mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_wr || resp_valid) bad = 1'b1;
    end
    check_eq("midrst_no_activity", {31'd0, bad}, 32'd0);

    // Continuous req_valid: one accept per IDLE cycle, none during RESP.
    wait_ready();
    req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h100;
    req_valid = 1'b1;
    n_acc = 0; n_resp = 0; acc0 = -1; acc1 = -1;
    for (int i = 0; i < 2 * (LAT + 2); i++) begin
      if (req_ready) begin
        if (n_acc == 0) acc0 = i; else if (n_acc == 1) acc1 = i;
        n_acc++;
      end
      if (resp_valid) n_resp++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check_eq("held_accepts", n_acc, 2);
    check_eq("held_first_accept", acc0, 0);
    check_eq("held_second_accept", acc1, LAT + 2);
    check_eq("held_responses", n_resp, 2);

    for (int t = 0; t < 60; t++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 1023)), $urandom, rd);
    end

    @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad = 1'b1;
    check_eq("final_memory", {31'd0, bad}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
